multiplier_sequencer: RTL and testbench
=======================================

Name: multiplier_sequencer

Overview:
- Initiator side of the Multiplier digit-test interface for V/N orders.
- Frames serial minor cycles from d0 and issues one dx digit-test pulse per multiplier digit, LSB first.
- Samples the dx_m response and drives accumulator add, subtract and shift gates for the following minor cycle.
- Emits an end pulse when all digits are processed; sits between order decode/CCU and the Multiplier tank / Accumulator.

Parameters:
- WORD_WIDTH, 36: bit times per minor cycle (serial word length).
- MPIER_BITS, 36: digits tested; digit MPIER_BITS-1 is the sign digit.

Ports:
- clk  input  1  system clock, one bit time per cycle.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a multiply sequence (V or N order, Stage 2).
- negate  input  1  N order; sampled on accepted start and held internally.
- d0  input  1  digit-0 pulse marking the first bit time of each minor cycle.
- dx_m  input  1  Multiplier response; high when the tested digit is 1.
- dx  output  1  digit test pulse to the Multiplier.
- add_gate  output  1  add multiplicand into accumulator during this minor cycle.
- sub_gate  output  1  subtract multiplicand during this minor cycle.
- shift_gate  output  1  shift accumulator right one place during this minor cycle.
- busy  output  1  high while a sequence is active.
- ep  output  1  one-cycle end pulse.
- digit_idx  output  6  current digit k under test or operation.

Behaviour:
- Reset (async):
  - State IDLE; all outputs 0.
  - pos=0, synced=0, k=0, hit=0, neg_q=0.
- Framing:
  - cur = d0 ? 0 : pos_q.
  - pos_q <= (cur==WORD_WIDTH-1) ? 0 : cur+1.
  - synced set on the first d0 after reset.
  - A d0 arriving when pos_q != 0 (out of phase) resyncs pos and aborts any active sequence to IDLE with no ep.
- State transitions occur only at edges where cur==WORD_WIDTH-1, so each state occupies whole minor cycles starting at d0.
- IDLE:
  - start -> ARM; latch neg_q=negate; k=0.
  - start while busy is ignored.
- ARM: at end of a minor cycle with synced=1 -> TEST; hit cleared.
- TEST:
  - dx = 1 exactly in the cycle where cur==k.
  - hit <= dx_m in that cycle; dx_m at any other time is ignored.
  - At end of minor cycle -> OP.
- OP (whole minor cycle, combinational from state):
  - sign = (k==MPIER_BITS-1).
  - add_gate = hit & (sign ? neg_q : ~neg_q).
  - sub_gate = hit & (sign ? ~neg_q : neg_q).
  - shift_gate = ~sign.
  - At end of minor cycle:
    - If sign: -> IDLE, with ep=1 registered for the first cycle of IDLE (the next d0 cycle).
    - Otherwise: k=k+1, hit=0, -> TEST.
- Timing:
  - busy = state in {ARM, TEST, OP}.
  - Total from first TEST to ep = 2*MPIER_BITS minor cycles.
- add_gate and sub_gate are never high together.
- digit_idx = k; 0 in IDLE.
- start coincident with the ep cycle is accepted (state is already IDLE).

Test Plan:
- Multiplier word 0x000000005, negate=0, start after sync:
  - dx pulses at cur=k for k=0..35.
  - add_gate only in OP steps 0 and 2.
  - shift_gate in OP steps 0..34.
  - ep exactly 72 minor cycles after the first TEST d0.
- Word 0x800000000 (sign only), negate=0 -> sub_gate in OP step 35 only; no add_gate ever.
- Word 0x000000001, negate=1 -> sub_gate in OP step 0; step 35 has neither gate; ep occurs.
- Second start pulse mid-sequence (k=10) -> ignored; digit_idx continues; a single ep.
- rst asserted at k=20 during TEST -> all outputs 0 immediately; busy stays 0 until the next start; no ep.
- Inject d0 at pos_q=17 during OP -> abort: busy=0 next cycle, no ep, framing realigned to the new d0.

Source files
------------

// File: rtl/multiplier_sequencer.sv
// Multiplier digit-test sequencer for V/N orders.
// Frames minor cycles from d0 and drives dx / accumulator gates.
module multiplier_sequencer #(
  parameter int WORD_WIDTH = 36,
  parameter int MPIER_BITS = 36
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       negate,
  input  logic       d0,
  input  logic       dx_m,
  output logic       dx,
  output logic       add_gate,
  output logic       sub_gate,
  output logic       shift_gate,
  output logic       busy,
  output logic       ep,
  output logic [5:0] digit_idx
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    TEST,
    OP
  } state_t;

  state_t     state_q;
  logic [5:0] pos_q;
  logic [5:0] pos_d;
  logic [5:0] cur;
  logic [5:0] k_q;
  logic       synced_q;
  logic       hit_q;
  logic       neg_q;
  logic       ep_q;
  logic       last;
  logic       resync;
  logic       sign;

  // Bit-time framing: d0 forces position 0, out-of-phase d0 resyncs
  always_comb begin
    cur    = d0 ? 6'd0 : pos_q;
    last   = (cur == 6'(WORD_WIDTH - 1));
    pos_d  = last ? 6'd0 : cur + 6'd1;
    resync = d0 && (pos_q != 6'd0);
    sign   = (k_q == 6'(MPIER_BITS - 1));
  end

  // Digit test and accumulator gates decoded from state
  always_comb begin
    busy       = (state_q != IDLE);
    dx         = (state_q == TEST) && (cur == k_q);
    add_gate   = (state_q == OP) && hit_q && (sign ? neg_q : !neg_q);
    sub_gate   = (state_q == OP) && hit_q && (sign ? !neg_q : neg_q);
    shift_gate = (state_q == OP) && !sign;
    digit_idx  = busy ? k_q : 6'd0;
    ep         = ep_q;
  end

  // Sequencer FSM; state moves only at minor-cycle boundaries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pos_q    <= 6'd0;
      synced_q <= 1'b0;
      k_q      <= 6'd0;
      hit_q    <= 1'b0;
      neg_q    <= 1'b0;
      ep_q     <= 1'b0;
    end else begin
      pos_q <= pos_d;
      ep_q  <= 1'b0;
      if (d0) begin
        synced_q <= 1'b1;
      end
      if (resync) begin
        state_q <= IDLE;
        k_q     <= 6'd0;
        hit_q   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              state_q <= ARM;
              neg_q   <= negate;
              k_q     <= 6'd0;
            end
          end
          ARM: begin
            if (last && synced_q) begin
              state_q <= TEST;
              hit_q   <= 1'b0;
            end
          end
          TEST: begin
            if (dx) begin
              hit_q <= dx_m;
            end
            if (last) begin
              state_q <= OP;
            end
          end
          OP: begin
            if (last) begin
              if (sign) begin
                state_q <= IDLE;
                ep_q    <= 1'b1;
                k_q     <= 6'd0;
              end else begin
                state_q <= TEST;
                k_q     <= k_q + 6'd1;
                hit_q   <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Testbench for multiplier_sequencer.
// Timeline model: expected outputs derived from minor-cycle arithmetic.
module tb_multiplier_sequencer;

  localparam int WW  = 36;
  localparam int MB  = 36;
  localparam int SEQ = 2 * MB * WW;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       negate;
  logic       d0;
  logic       dx_m;
  logic       dx;
  logic       add_gate;
  logic       sub_gate;
  logic       shift_gate;
  logic       busy;
  logic       ep;
  logic [5:0] digit_idx;
  logic [11:0] outs;

  always #5 clk = ~clk;

  multiplier_sequencer #(
    .WORD_WIDTH(WW),
    .MPIER_BITS(MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .negate    (negate),
    .d0        (d0),
    .dx_m      (dx_m),
    .dx        (dx),
    .add_gate  (add_gate),
    .sub_gate  (sub_gate),
    .shift_gate(shift_gate),
    .busy      (busy),
    .ep        (ep),
    .digit_idx (digit_idx)
  );

  assign outs = {dx, add_gate, sub_gate, shift_gate, busy, ep, digit_idx};

  typedef struct {
    logic [35:0] word;
    logic        neg;
    int          sph;
    int          n_add;
    int          n_sub;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ph = 0;
  int mode = 0;
  int start_c = 0;
  int t0 = 0;
  int ep_at = -1;
  logic [35:0] m_word = '0;
  logic [35:0] word_in = '0;
  logic        m_neg = 1'b0;
  string tag = "idle";
  int cnt_dx, cnt_add, cnt_sub, cnt_sh, cnt_ep;

  task automatic check(input string nm, input logic [11:0] act,
                       input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic clr_cnt();
    cnt_dx = 0; cnt_add = 0; cnt_sub = 0; cnt_sh = 0; cnt_ep = 0;
  endtask

  // One clock: drive at negedge, compare at negedge+1, update model at posedge
  task automatic cycle(input logic st, input logic nd, input logic inj);
    int t, mc, b, k, pm;
    logic op, h, sg;
    logic edx, ead, esb, esh, ebz, eep;
    logic [5:0] eix;
    @(negedge clk);
    d0 = (ph == 0) || inj;
    start = st;
    negate = nd;
    if (mode == 1 && d0 && cyc >= start_c + 2) begin
      mode = 2;
      t0 = cyc;
    end
    edx = 0; ead = 0; esb = 0; esh = 0; ebz = 0; eix = '0; t = 0;
    dx_m = 1'($urandom);
    if (mode == 2) begin
      t = cyc - t0;
      mc = t / WW;
      b = t % WW;
      k = mc / 2;
      op = (mc % 2) == 1;
      h = m_word[k];
      sg = (k == MB - 1);
      if (!op && b == k) begin
        dx_m = h;
        edx = 1;
      end
      ead = op && h && (sg ? m_neg : !m_neg);
      esb = op && h && (sg ? !m_neg : m_neg);
      esh = op && !sg;
      ebz = 1;
      eix = 6'(k);
    end else if (mode == 1) begin
      ebz = 1;
    end
    eep = (cyc == ep_at);
    #1;
    check(tag, outs, {edx, ead, esb, esh, ebz, eep, eix});
    cnt_dx += int'(dx);
    cnt_add += int'(add_gate);
    cnt_sub += int'(sub_gate);
    cnt_sh += int'(shift_gate);
    cnt_ep += int'(ep);
    @(posedge clk);
    pm = mode;
    if (inj) begin
      mode = 0;
    end else if (mode == 2 && t == SEQ - 1) begin
      mode = 0;
      ep_at = cyc + 1;
    end
    if (pm == 0 && st && !inj) begin
      mode = 1;
      start_c = cyc;
      m_word = word_in;
      m_neg = nd;
    end
    ph = inj ? 1 : (ph + 1) % WW;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  task automatic wait_ph(input int p);
    for (int i = 0; i < WW + 2 && ph != p; i++) cycle(0, 0, 0);
  endtask

  task automatic go(input logic [35:0] w, input logic n);
    word_in = w;
    cycle(1, n, 0);
  endtask

  task automatic run_to(input int tgt);
    logic ok;
    ok = 0;
    for (int i = 0; i < SEQ + 200; i++) begin
      if (mode == 2 && cyc - t0 == tgt) begin
        ok = 1;
        break;
      end
      cycle(0, 0, 0);
    end
    check("run_to_reached", {11'd0, ok}, 12'd1);
  endtask

  task automatic finish_seq();
    logic ok;
    ok = 0;
    for (int i = 0; i < SEQ + 200; i++) begin
      if (mode == 0 && cyc > ep_at) begin
        ok = 1;
        break;
      end
      cycle(0, 0, 0);
    end
    check("seq_done", {11'd0, ok}, 12'd1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    d0 = (ph == 0);
    rst = 1;
    start = 0;
    #1;
    check("rst_async", outs, 12'd0);
    @(posedge clk);
    ph = (ph + 1) % WW;
    cyc++;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d0 = (ph == 0);
      #1;
      check("rst_hold", outs, 12'd0);
      @(posedge clk);
      ph = (ph + 1) % WW;
      cyc++;
    end
    #2;
    rst = 0;
    mode = 0;
    ep_at = -1;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{36'h000000005, 1'b0, 0,  2,  0};
    vecs[1] = '{36'h800000000, 1'b0, 35, 0,  1};
    vecs[2] = '{36'h000000001, 1'b1, 10, 0,  1};
    vecs[3] = '{36'h800000001, 1'b1, 34, 1,  1};
    vecs[4] = '{36'hFFFFFFFFF, 1'b0, 20, 35, 1};
    vecs[5] = '{36'h000000000, 1'b1, 5,  0,  0};

    rst = 1; start = 0; negate = 0; d0 = 0; dx_m = 0;
    clr_cnt();
    repeat (2) @(negedge clk);
    #1;
    check("reset", outs, 12'd0);
    @(posedge clk);
    #2;
    rst = 0;
    idle(80);

    for (int i = 0; i < 6; i++) begin
      tag = $sformatf("vec%0d", i);
      wait_ph(vecs[i].sph);
      clr_cnt();
      go(vecs[i].word, vecs[i].neg);
      finish_seq();
      check({tag, "_add"}, 12'(cnt_add), 12'(vecs[i].n_add * WW));
      check({tag, "_sub"}, 12'(cnt_sub), 12'(vecs[i].n_sub * WW));
      check({tag, "_shift"}, 12'(cnt_sh), 12'((MB - 1) * WW));
      check({tag, "_dx"}, 12'(cnt_dx), 12'(MB));
      check({tag, "_ep"}, 12'(cnt_ep), 12'd1);
      idle(7);
    end

    for (int i = 0; i < 3; i++) begin
      tag = $sformatf("rand%0d", i);
      wait_ph(int'($urandom_range(0, WW - 1)));
      clr_cnt();
      go({$urandom, 4'($urandom)}, 1'($urandom));
      finish_seq();
      check({tag, "_ep"}, 12'(cnt_ep), 12'd1);
      idle(3);
    end

    tag = "midstart";
    clr_cnt();
    go({$urandom, 4'($urandom)}, 1'b0);
    run_to(20 * WW + 5);
    cycle(1, 1, 0);
    finish_seq();
    check("midstart_ep", 12'(cnt_ep), 12'd1);
    check("midstart_dx", 12'(cnt_dx), 12'(MB));

    tag = "reset_seq";
    idle(5);
    clr_cnt();
    go({$urandom, 4'($urandom)}, 1'($urandom));
    run_to(40 * WW + 7);
    do_reset(2);
    idle(80);
    check("rst_no_ep", 12'(cnt_ep), 12'd0);

    tag = "abort";
    wait_ph(3);
    clr_cnt();
    go(36'hFFFFFFFFF, 1'b0);
    run_to(11 * WW + 17);
    cycle(0, 0, 1);
    idle(80);
    check("abort_no_ep", 12'(cnt_ep), 12'd0);

    tag = "chain";
    wait_ph(0);
    clr_cnt();
    go(36'h000000005, 1'b0);
    run_to(SEQ - 1);
    cycle(0, 0, 0);
    go(36'h800000001, 1'b1);
    finish_seq();
    check("chain_ep", 12'(cnt_ep), 12'd2);
    check("chain_dx", 12'(cnt_dx), 12'(2 * MB));
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
